// File: rtl/johnson_digit_counter.sv
// Prescaled bidirectional 5-bit Johnson decade counter.
// Drives the ring code to the segment decoder and also provides the binary digit, a wrap pulse and an error pulse.
module johnson_digit_counter #(
  parameter int unsigned PRESCALE = 50000000,
  parameter int unsigned PS_W     = 26
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       up,
  input  logic       load,
  input  logic [3:0] load_digit,
  output logic [4:0] c,
  output logic [3:0] digit,
  output logic       carry,
  output logic       err
);

  localparam logic [PS_W-1:0] PS_LAST  = PS_W'(PRESCALE - 1);
  localparam logic [3:0]      DIGIT_MAX = 4'd9;

  logic [4:0]      c_q, c_d;
  logic [3:0]      digit_q, digit_d;
  logic [PS_W-1:0] ps_q, ps_d;
  logic            carry_q, carry_d;
  logic            err_q, err_d;

  logic            legal;
  logic            step;
  logic            load_ok;

  function automatic logic is_legal(input logic [4:0] code);
    case (code)
      5'b00000, 5'b00001, 5'b00011, 5'b00111, 5'b01111,
      5'b11111, 5'b11110, 5'b11100, 5'b11000, 5'b10000: return 1'b1;
      default:                                          return 1'b0;
    endcase
  endfunction

  function automatic logic [4:0] encode(input logic [3:0] d);
    case (d)
      4'd0:    return 5'b00000;
      4'd1:    return 5'b00001;
      4'd2:    return 5'b00011;
      4'd3:    return 5'b00111;
      4'd4:    return 5'b01111;
      4'd5:    return 5'b11111;
      4'd6:    return 5'b11110;
      4'd7:    return 5'b11100;
      4'd8:    return 5'b11000;
      4'd9:    return 5'b10000;
      default: return 5'b00000;
    endcase
  endfunction

  assign legal   = is_legal(c_q);
  assign step    = en && (ps_q == PS_LAST);
  assign load_ok = (load_digit <= DIGIT_MAX);

  // Recovery outranks load, and load outranks step.
  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
    c_d     = c_q;
    digit_d = digit_q;
    ps_d    = ps_q;
    carry_d = 1'b0;
    err_d   = 1'b0;

    if (!legal) begin
      c_d     = 5'b00000;
      digit_d = 4'd0;
      ps_d    = '0;
      err_d   = 1'b1;
    end else if (load) begin
      if (load_ok) begin
        c_d     = encode(load_digit);
        digit_d = load_digit;
        ps_d    = '0;
      end else begin
        err_d   = 1'b1;
      end
    end else if (step) begin
      ps_d = '0;
      if (up) begin
        c_d = {c_q[3:0], ~c_q[4]};
        if (digit_q == DIGIT_MAX) begin
          digit_d = 4'd0;
          carry_d = 1'b1;
        end else begin
          digit_d = digit_q + 4'd1;
        end
      end else begin
        c_d = {~c_q[0], c_q[4:1]};
        if (digit_q == 4'd0) begin
          digit_d = DIGIT_MAX;
          carry_d = 1'b1;
        end else begin
          digit_d = digit_q - 4'd1;
        end
      end
    end else if (en) begin
      ps_d = ps_q + 1'b1;
    end
  end

  // NOTE: reset is sampled on the clock edge only; rst_n is not in the sensitivity list.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
    if (!rst_n) begin
      c_q     <= 5'b00000;
      digit_q <= 4'd0;
      ps_q    <= '0;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      c_q     <= c_d;
      digit_q <= digit_d;
      ps_q    <= ps_d;
      carry_q <= carry_d;
      err_q   <= err_d;
    end
  end

  assign c     = c_q;
  assign digit = digit_q;
  assign carry = carry_q;
  assign err   = err_q;

endmodule

// File: tb/tb_johnson_digit_counter.sv
// Directed bench for johnson_digit_counter: PRESCALE=4 main instance plus a PRESCALE=1 instance.
module tb_johnson_digit_counter;

  logic       clk = 1'b0;
  logic       rst_n, en, up, load;
  logic [3:0] load_digit;
  logic [4:0] c;
  logic [3:0] digit;
  logic       carry, err;

  logic       rst1_n, en1, up1, load1;
  logic [3:0] load_digit1;
  logic [4:0] c1;
  logic [3:0] digit1;
  logic       carry1, err1;

  int checks   = 0;
  int failures = 0;

  // Legal codes for digits 0..9, written out by hand.
  logic [4:0] codes [10] = '{5'b00000, 5'b00001, 5'b00011, 5'b00111, 5'b01111,
                             5'b11111, 5'b11110, 5'b11100, 5'b11000, 5'b10000};

  always #5 clk = ~clk;

  johnson_digit_counter #(.PRESCALE(4), .PS_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load),
    .load_digit(load_digit), .c(c), .digit(digit), .carry(carry), .err(err)
  );

  johnson_digit_counter #(.PRESCALE(1), .PS_W(1)) dut1 (
    .clk(clk), .rst_n(rst1_n), .en(en1), .up(up1), .load(load1),
    .load_digit(load_digit1), .c(c1), .digit(digit1), .carry(carry1), .err(err1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic check_out(input string tag, input int d, input logic cy, input logic er);
    check({tag, ".c"}, 32'(c), 32'(codes[d]));
    check({tag, ".digit"}, 32'(digit), 32'(d));
    check({tag, ".carry"}, 32'(carry), 32'(cy));
    check({tag, ".err"}, 32'(err), 32'(er));
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; load_digit = 4'd0;
    rst1_n = 1'b0; en1 = 1'b0; up1 = 1'b1; load1 = 1'b0; load_digit1 = 4'd0;
    tick(2);

    // Reset state
    check_out("reset", 0, 1'b0, 1'b0);
    check("reset.ps", 32'(dut.ps_q), 32'd0);

    // Count up through a full decade: one step per 4 clocks, carry on 9->0
    rst_n = 1'b1; en = 1'b1; up = 1'b1;
    for (int k = 1; k <= 44; k++) begin
      tick();
      check_out($sformatf("up_k%0d", k), (k / 4) % 10, (k == 40), 1'b0);
    end

    // Count down from reset: first step wraps 0->9 with carry
    do_reset();
    up = 1'b0;
    tick(3);
    check_out("down_pre", 0, 1'b0, 1'b0);
    tick();
    check_out("down_s1", 9, 1'b1, 1'b0);
    tick();
    check("down_carry_once", 32'(carry), 32'd0);
    tick(3);
    check_out("down_s2", 8, 1'b0, 1'b0);

    // Load 7 on a step cycle: load wins, no carry, ps restarts
    up = 1'b1;
    tick(3);
    check("load_pre_ps", 32'(dut.ps_q), 32'd3);
    load = 1'b1; load_digit = 4'd7;
    tick();
    load = 1'b0;
    check_out("load7", 7, 1'b0, 1'b0);
    check("load7.ps", 32'(dut.ps_q), 32'd0);
    tick(3);
    check_out("load7_hold", 7, 1'b0, 1'b0);
    tick();
    check_out("load7_step", 8, 1'b0, 1'b0);

    // Rejected load of 12: outputs unchanged, one-cycle err
    load = 1'b1; load_digit = 4'd12;
    tick();
    load = 1'b0;
    check_out("load12", 8, 1'b0, 1'b1);
    tick();
    check_out("load12_after", 8, 1'b0, 1'b0);

    // Illegal code 01010 recovers on the next edge; concurrent load ignored
    force dut.c_q = 5'b01010;
    release dut.c_q;
    load = 1'b1; load_digit = 4'd3;
    tick();
    load = 1'b0;
    check_out("illegal", 0, 1'b0, 1'b1);
    check("illegal.ps", 32'(dut.ps_q), 32'd0);
    tick();
    check_out("illegal_after", 0, 1'b0, 1'b0);

    // en low for 3 cycles at ps=2 delays the step by exactly 3 clocks
    do_reset();
    en = 1'b1; up = 1'b1;
    tick(2);
    check("en_gap.ps2", 32'(dut.ps_q), 32'd2);
    en = 1'b0;
    tick(3);
    check("en_gap.ps_hold", 32'(dut.ps_q), 32'd2);
    en = 1'b1;
    tick();
    check_out("en_gap_t6", 0, 1'b0, 1'b0);
    tick();
    check_out("en_gap_t7", 1, 1'b0, 1'b0);

    // en dropped on a step cycle: ps holds at 3, step fires when en returns
    tick(3);
    check("en_stepcyc.ps", 32'(dut.ps_q), 32'd3);
    en = 1'b0;
    tick(2);
    check_out("en_stepcyc_hold", 1, 1'b0, 1'b0);
    check("en_stepcyc.ps_hold", 32'(dut.ps_q), 32'd3);
    en = 1'b1;
    tick();
    check_out("en_stepcyc_fire", 2, 1'b0, 1'b0);

    // Reach digit 5 mid-period, then a 1-clock reset clears everything
    tick(12);
    tick(2);
    check_out("pre_rst5", 5, 1'b0, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_out("rst5", 0, 1'b0, 1'b0);
    check("rst5.ps", 32'(dut.ps_q), 32'd0);
    en = 1'b0;

    // PRESCALE=1: a step every clock, carry every 10th clock
    rst1_n = 1'b1; en1 = 1'b1; up1 = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      check($sformatf("ps1_k%0d.c", k), 32'(c1), 32'(codes[k % 10]));
      check($sformatf("ps1_k%0d.carry", k), 32'(carry1), 32'(k % 10 == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
